// File: rtl/ws2812_pixel_buffer.sv
// ws2812_pixel_buffer: CPU-mapped pixel store feeding a WS2812 bit serializer.
// The CPU writes colours through an index/R/G/B staging window. A CTRL start
// streams every pixel out over valid/ready, waits for the serializer to drain,
// then holds busy through the latch gap.
// Optional feature: define WS2812_BRIGHTNESS_EN for a global brightness register (reg 6).
module ws2812_pixel_buffer #(
  parameter int NUM_PIXELS = 8,
  parameter int CLK_FRE    = 25_175_000,
  parameter int RESET_US   = 60
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_cs,
  input  logic        R_W_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic [23:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  input  logic        ser_busy_i,
  output logic        busy_o
);

  localparam int RESET_CYCLES = CLK_FRE / 1_000_000 * RESET_US;
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [8:0]    NP9      = 9'(NUM_PIXELS);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_PIXELS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, DRAIN, GAP} state_t;

  state_t        state_q;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic [23:0]   ram_q [NUM_PIXELS];
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [23:0]   word_q;
  logic          valid_q, busy_q, gap_q;

  logic wr_en, commit, start;
  assign wr_en  = pix_cs & ~R_W_n;
  assign commit = wr_en && (reg_addr_i == 3'd3);
  assign start  = wr_en && (reg_addr_i == 3'd4) && data_i[0] && !busy_q && (state_q == IDLE);

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q, bright_d;

  // Channel scale (c*(BRIGHT+1))>>8; BRIGHT=FF is the identity.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return p[15:8];
  endfunction

  assign pix_data_o = {scale(word_q[23:16], bright_q), scale(word_q[15:8], bright_q),
                       scale(word_q[7:0], bright_q)};
`else
  assign pix_data_o = word_q;
`endif

  assign pix_valid_o = valid_q;
  assign busy_o      = busy_q;

  // CPU register next-state: index load/auto-increment and staging bytes.
  always_comb begin
    idx_d = idx_q;
    r_d   = r_q;
    g_d   = g_q;
    b_d   = b_q;
`ifdef WS2812_BRIGHTNESS_EN
    bright_d = bright_q;
`endif
    if (wr_en) begin
      case (reg_addr_i)
        3'd0: idx_d = ({1'b0, data_i} >= NP9) ? 8'd0 : data_i;
        3'd1: r_d = data_i;
        3'd2: g_d = data_i;
        3'd3: begin
          b_d   = data_i;
          idx_d = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
        end
`ifdef WS2812_BRIGHTNESS_EN
        3'd6: bright_d = data_i;
`endif
        default: ;
      endcase
    end
  end

  // CPU register state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q <= 8'hFF;
`endif
    end else begin
      idx_q <= idx_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  // Pixel RAM: B write commits {G,R,B}; the FETCH read sees pre-write data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PIXELS; i++) ram_q[i] <= '0;
    end else if (commit) begin
      ram_q[idx_q[PW-1:0]] <= {g_q, r_q, data_i};
    end
  end

  // Frame sequencer: fetch, present until accepted, drain serializer, latch gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q  <= FETCH;
          rd_ptr_q <= '0;
          busy_q   <= 1'b1;
        end
        FETCH: begin
          word_q  <= ram_q[rd_ptr_q];
          valid_q <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: if (pix_ready_i) begin
          valid_q <= 1'b0;
          if (rd_ptr_q == LAST_PTR) state_q <= DRAIN;
          else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            state_q  <= FETCH;
          end
        end
        DRAIN: if (!ser_busy_i) begin
          state_q <= GAP;
          cnt_q   <= '0;
          gap_q   <= 1'b1;
        end
        GAP: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gap_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // CPU read mux, combinational on the address.
  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      3'd0: data_o = idx_q;
      3'd1: data_o = r_q;
      3'd2: data_o = g_q;
      3'd3: data_o = b_q;
      3'd4: data_o = {6'b0, gap_q, busy_q};
      3'd5: data_o = LAST_IDX;
`ifdef WS2812_BRIGHTNESS_EN
      3'd6: data_o = bright_q;
`endif
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812_pixel_buffer.sv
// Bench for ws2812_pixel_buffer: register vector table, directed frames and
// randomized frames checked against an array model of the pixel store.
module tb_ws2812_pixel_buffer;
  localparam int NP  = 8;
  localparam int CF  = 1_000_000;
  localparam int RUS = 20;
  localparam int RC  = CF / 1_000_000 * RUS;
`ifdef WS2812_BRIGHTNESS_EN
  localparam logic [7:0] BR_RST = 8'hFF;
`else
  localparam logic [7:0] BR_RST = 8'h00;
`endif

  logic clk = 0;
  logic rst_i, pix_cs, R_W_n, pix_ready_i, ser_busy_i;
  logic [2:0] reg_addr_i;
  logic [7:0] data_i, data_o;
  logic [23:0] pix_data_o;
  logic pix_valid_o, busy_o;

  ws2812_pixel_buffer #(.NUM_PIXELS(NP), .CLK_FRE(CF), .RESET_US(RUS)) dut (
    .clk_i(clk), .rst_i(rst_i), .pix_cs(pix_cs), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
    .data_i(data_i), .data_o(data_o), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .ser_busy_i(ser_busy_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model of the CPU-visible store.
  logic [23:0] ref_ram [NP];
  int          ref_idx;
  logic [7:0]  ref_r, ref_g, ref_bright;
  logic [23:0] rx [NP];

  typedef struct { bit wr; logic [2:0] a; logic [7:0] d; logic [7:0] exp; } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic mdl_reset;
    for (int i = 0; i < NP; i++) ref_ram[i] = '0;
    ref_idx = 0; ref_r = 0; ref_g = 0; ref_bright = 8'hFF;
  endtask

  task automatic mdl_wr(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0: ref_idx = (int'(d) >= NP) ? 0 : int'(d);
      3'd1: ref_r = d;
      3'd2: ref_g = d;
      3'd3: begin
        ref_ram[ref_idx] = {ref_g, ref_r, d};
        ref_idx = (ref_idx + 1) % NP;
      end
`ifdef WS2812_BRIGHTNESS_EN
      3'd6: ref_bright = d;
`endif
      default: ;
    endcase
  endtask

  function automatic logic [23:0] scaled(input logic [23:0] w, input logic [7:0] b);
    logic [23:0] o;
    for (int c = 0; c < 3; c++) o[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) * (int'(b) + 1)) / 256);
    return o;
  endfunction

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    pix_cs = 1; R_W_n = 0; reg_addr_i = a; data_i = d;
    mdl_wr(a, d);
    tick;
    pix_cs = 0; R_W_n = 1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    pix_cs = 1; R_W_n = 1; reg_addr_i = a;
    #1 d = data_o;
    pix_cs = 0;
  endtask

  // Start a frame, collect all pixels with random ready, then time the tail.
  task automatic run_frame(input int rdy_pct, input bit stall5, input bit midwr, input int hold);
    int got, cyc, stall, step, n;
    bit prev_stall, done;
    logic [23:0] prev_data;
    logic [2:0] wa;
    logic [7:0] wd, rd;
    cpu_wr(3'd4, 8'h01);
    chk("busy_after_start", busy_o, 1);
    ser_busy_i = (hold > 0);
    got = 0; cyc = 0; stall = 0; step = 0; prev_stall = 0; prev_data = '0;
    while (got < NP && cyc < 3000) begin
      pix_cs = 0; R_W_n = 1;
      if (midwr && got >= 1 && step < 5) begin
        case (step)
          0: begin wa = 3'd0; wd = 8'd6; end
          1: begin wa = 3'd1; wd = 8'($urandom); end
          2: begin wa = 3'd2; wd = 8'($urandom); end
          3: begin wa = 3'd3; wd = 8'($urandom); end
          default: begin wa = 3'd4; wd = 8'h01; end
        endcase
        pix_cs = 1; R_W_n = 0; reg_addr_i = wa; data_i = wd;
        mdl_wr(wa, wd);
        step++;
      end
      pix_ready_i = ($urandom_range(99) < rdy_pct);
      if (stall5 && got == 3 && stall < 5 && pix_valid_o) begin
        pix_ready_i = 0; stall++;
      end
      if (prev_stall) begin
        chk("hold_valid", pix_valid_o, 1);
        chk("hold_data", pix_data_o, prev_data);
      end
      if (pix_valid_o && pix_ready_i) begin
        rx[got] = pix_data_o; got++;
      end
      prev_stall = pix_valid_o && !pix_ready_i;
      prev_data  = pix_data_o;
      tick; cyc++;
    end
    pix_cs = 0; R_W_n = 1; pix_ready_i = 0;
    chk("frame_len", got, NP);
    for (int i = 0; i < got; i++) chk($sformatf("pix%0d", i), rx[i], scaled(ref_ram[i], ref_bright));
    tick;
    chk("no_extra_valid", pix_valid_o, 0);
    for (int h = 1; h < hold; h++) begin
      cpu_rd(3'd4, rd);
      chk("drain_ctrl", rd, 8'h01);
      tick;
    end
    ser_busy_i = 0;
    // The first tick below already happened above for hold>0; rebase the count.
    n = (hold > 0) ? 0 : 1;
    done = (hold == 0) && !busy_o;
    while (!done && n < RC + 50) begin
      pix_cs = 0; R_W_n = 1; reg_addr_i = 3'd4;
      if (n == RC) begin pix_cs = 1; R_W_n = 0; data_i = 8'h01; end
      if (n == 1) begin #1 chk("gap_ctrl", data_o, 8'h03); end
      tick; n++;
      if (!busy_o) done = 1;
    end
    pix_cs = 0; R_W_n = 1;
    chk("gap_len", n, RC + 1);
    repeat (3) begin
      tick;
      chk("idle_busy", busy_o, 0);
      chk("idle_valid", pix_valid_o, 0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int wait_cyc;
    rst_i = 1; pix_cs = 0; R_W_n = 1; reg_addr_i = 0; data_i = 0;
    pix_ready_i = 0; ser_busy_i = 0;
    mdl_reset;
    repeat (2) tick;
    rst_i = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", pix_valid_o, 0);
    chk("rst_data", pix_data_o, 0);

    tbl.push_back('{0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{0, 3'd4, 8'h00, 8'h00});
    tbl.push_back('{0, 3'd5, 8'h00, 8'(NP - 1)});
    tbl.push_back('{0, 3'd6, 8'h00, BR_RST});
    tbl.push_back('{0, 3'd7, 8'h00, 8'h00});
    tbl.push_back('{1, 3'd0, 8'h02, 8'h00});
    tbl.push_back('{1, 3'd1, 8'h11, 8'h00});
    tbl.push_back('{1, 3'd2, 8'h22, 8'h00});
    tbl.push_back('{1, 3'd3, 8'h33, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 8'h03});
    tbl.push_back('{1, 3'd0, 8'h07, 8'h00});
    tbl.push_back('{1, 3'd1, 8'hAA, 8'h00});
    tbl.push_back('{1, 3'd2, 8'hBB, 8'h00});
    tbl.push_back('{1, 3'd3, 8'hCC, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{1, 3'd0, 8'h09, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{1, 3'd0, 8'h05, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 8'h05});
    tbl.push_back('{1, 3'd0, 8'h08, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 8'h00});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) cpu_wr(tbl[i].a, tbl[i].d);
      else begin
        cpu_rd(tbl[i].a, rd);
        chk($sformatf("tbl%0d_reg%0d", i, tbl[i].a), rd, tbl[i].exp);
      end
    end

    // Frame with ready tied high; pixel 2 holds the directed colour.
    run_frame(100, 0, 0, 0);
    chk("pix2_const", rx[2], 24'h221133);
    chk("pix0_const", rx[0], 24'h000000);

    // Stall of 5 cycles, writes/start while busy, serializer busy for 10 cycles.
    run_frame(100, 1, 1, 10);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(3, 10)) begin
        cpu_wr(3'd0, 8'($urandom_range(0, 11)));
        cpu_wr(3'd1, 8'($urandom));
        cpu_wr(3'd2, 8'($urandom));
        cpu_wr(3'd3, 8'($urandom));
      end
      run_frame($urandom_range(30, 90), f[0], f[1], $urandom_range(0, 6));
    end

    // Reset while a pixel is presented.
    cpu_wr(3'd4, 8'h01);
    pix_ready_i = 0;
    wait_cyc = 0;
    while (!pix_valid_o && wait_cyc < 20) begin tick; wait_cyc++; end
    chk("present_reached", pix_valid_o, 1);
    rst_i = 1;
    tick;
    rst_i = 0;
    mdl_reset;
    chk("midrst_valid", pix_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    run_frame(70, 0, 0, 0);

    // Brightness.
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd1, 8'hFF);
    cpu_wr(3'd2, 8'hFF);
    cpu_wr(3'd3, 8'hFF);
    cpu_wr(3'd6, 8'h7F);
    cpu_rd(3'd6, rd);
`ifdef WS2812_BRIGHTNESS_EN
    chk("bright_rd", rd, 8'h7F);
`else
    chk("bright_rd", rd, 8'h00);
`endif
    run_frame(100, 0, 0, 0);
`ifdef WS2812_BRIGHTNESS_EN
    chk("bright_pix", rx[0], 24'h7F7F7F);
`else
    chk("bright_pix", rx[0], 24'hFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
